// File: rtl/conv3x3_pad_stream.sv
// Streaming 3x3 convolution with an internal one-pixel zero border and a run-time loadable signed kernel.
// Optional feature: define CONV_SAT_EN to clamp outputs to [0, 2^OUT_W-1] instead of truncating.
module conv3x3_pad_stream #(
  parameter int IMG_W  = 9,
  parameter int IMG_H  = 9,
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int OUT_W  = 8,
  parameter int SHIFT  = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     coef_we_i,
  input  logic [3:0]               coef_addr_i,
  input  logic signed [COEF_W-1:0] coef_data_i,
  input  logic                     start_i,
  input  logic                     s_valid_i,
  output logic                     s_ready_o,
  input  logic [DATA_W-1:0]        s_data_i,
  output logic                     m_valid_o,
  input  logic                     m_ready_i,
  output logic [OUT_W-1:0]         m_data_o,
  output logic                     m_last_o,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam int ACC_W = DATA_W + COEF_W + 4;
  localparam int PW    = IMG_W + 2;
  localparam int PH    = IMG_H + 2;
  localparam int CW    = $clog2(PW);
  localparam int RW    = $clog2(PH);
  localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((64'd1 << OUT_W) - 64'd1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

  state_e                   state_q, state_d;
  logic [RW-1:0]            pr_q, pr_d;
  logic [CW-1:0]            pc_q, pc_d;
  logic                     scan_end_q, scan_end_d;
  logic                     m_valid_q, m_valid_d;
  logic                     m_last_q, m_last_d;
  logic [OUT_W-1:0]         m_data_q, m_data_d;
  logic signed [COEF_W-1:0] coef_q [9];
  logic [DATA_W-1:0]        lb0_q [PW];
  logic [DATA_W-1:0]        lb1_q [PW];
  logic [DATA_W-1:0]        w1_q [3];
  logic [DATA_W-1:0]        w2_q [3];

  logic                     interior_s, slot_free_s, adv_s, fire_s, last_pos_s;
  logic [DATA_W-1:0]        px_s;
  logic [DATA_W-1:0]        col_s [3];
  logic [DATA_W-1:0]        win_s [9];
  logic signed [ACC_W-1:0]  acc_s, sh_s;
  logic [OUT_W-1:0]         y_s;

  // Scan position classification and handshake qualification.
  always_comb begin
    interior_s  = (pr_q >= RW'(1)) && (pr_q <= RW'(IMG_H)) &&
                  (pc_q >= CW'(1)) && (pc_q <= CW'(IMG_W));
    slot_free_s = !m_valid_q || m_ready_i;
    last_pos_s  = (pr_q == RW'(PH - 1)) && (pc_q == CW'(PW - 1));
    adv_s       = (state_q == RUN) && !scan_end_q && slot_free_s && (!interior_s || s_valid_i);
    fire_s      = adv_s && (pr_q >= RW'(2)) && (pc_q >= CW'(2));
    s_ready_o   = (state_q == RUN) && !scan_end_q && interior_s && slot_free_s;
  end

  // Window seen by the MAC: two stored columns plus the column entering this cycle.
  always_comb begin
    px_s     = interior_s ? s_data_i : {DATA_W{1'b0}};
    col_s[0] = lb1_q[pc_q];
    col_s[1] = lb0_q[pc_q];
    col_s[2] = px_s;
    for (int i = 0; i < 3; i++) begin
      win_s[3*i]   = w1_q[i];
      win_s[3*i+1] = w2_q[i];
      win_s[3*i+2] = col_s[i];
    end
  end

  // Signed multiply-accumulate, shift and output conversion.
  always_comb begin
    acc_s = {ACC_W{1'b0}};
    for (int k = 0; k < 9; k++) begin
      acc_s = acc_s + ($signed({{(ACC_W-DATA_W){1'b0}}, win_s[k]}) *
                       $signed({{(ACC_W-COEF_W){coef_q[k][COEF_W-1]}}, coef_q[k]}));
    end
    sh_s = acc_s >>> SHIFT;
`ifdef CONV_SAT_EN
    if (sh_s[ACC_W-1]) begin
      y_s = {OUT_W{1'b0}};
    end else if (sh_s > OUT_MAX) begin
      y_s = {OUT_W{1'b1}};
    end else begin
      y_s = sh_s[OUT_W-1:0];
    end
`else
    y_s = sh_s[OUT_W-1:0];
`endif
  end

  // Next-state logic for the frame FSM, scan counters and output slot.
  always_comb begin
    state_d    = state_q;
    pr_d       = pr_q;
    pc_d       = pc_q;
    scan_end_d = scan_end_q;
    m_valid_d  = m_valid_q;
    m_last_d   = m_last_q;
    m_data_d   = m_data_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d    = RUN;
          pr_d       = {RW{1'b0}};
          pc_d       = {CW{1'b0}};
          scan_end_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (adv_s && last_pos_s) begin
          scan_end_d = 1'b1;
        end else if (adv_s && (pc_q == CW'(PW - 1))) begin
          pc_d = {CW{1'b0}};
          pr_d = pr_q + RW'(1);
        end else if (adv_s) begin
          pc_d = pc_q + CW'(1);
        end else begin
          pc_d = pc_q;
        end
        if (m_valid_q && m_ready_i && m_last_q) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (fire_s) begin
      m_valid_d = 1'b1;
      m_data_d  = y_s;
      m_last_d  = last_pos_s;
    end else if (m_ready_i) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end else begin
      m_valid_d = m_valid_q;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      pr_q       <= {RW{1'b0}};
      pc_q       <= {CW{1'b0}};
      scan_end_q <= 1'b0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      m_data_q   <= {OUT_W{1'b0}};
    end else begin
      state_q    <= state_d;
      pr_q       <= pr_d;
      pc_q       <= pc_d;
      scan_end_q <= scan_end_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      m_data_q   <= m_data_d;
    end
  end

  // Kernel registers; reset value is the identity kernel.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < 9; k++) begin
        coef_q[k] <= (k == 4) ? COEF_W'(1) : {COEF_W{1'b0}};
      end
    end else if ((state_q == IDLE) && coef_we_i) begin
      for (int k = 0; k < 9; k++) begin
        if (coef_addr_i == 4'(k)) begin
          coef_q[k] <= coef_data_i;
        end
      end
    end
  end

  // Line buffers and window columns; padded row 0 flushes stale data before it is read.
  always_ff @(posedge clk_i) begin
    if (adv_s) begin
      lb1_q[pc_q] <= lb0_q[pc_q];
      lb0_q[pc_q] <= px_s;
      for (int i = 0; i < 3; i++) begin
        w1_q[i] <= w2_q[i];
        w2_q[i] <= col_s[i];
      end
    end
  end

  assign m_valid_o = m_valid_q;
  assign m_data_o  = m_data_q;
  assign m_last_o  = m_last_q;
  assign busy_o    = (state_q == RUN);
  assign done_o    = (state_q == DONE);

endmodule

// File: tb/tb_conv3x3_pad_stream.sv
// Directed self-checking bench for conv3x3_pad_stream (9x9, 8-bit); expectations follow CONV_SAT_EN.
module tb_conv3x3_pad_stream;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              coef_we = 1'b0;
  logic [3:0]        coef_addr = 4'd0;
  logic signed [7:0] coef_data = 8'sd0;
  logic              start = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [7:0]        s_data = 8'd0;
  logic              m_valid;
  logic              m_ready = 1'b1;
  logic [7:0]        m_data;
  logic              m_last;
  logic              busy;
  logic              done;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef CONV_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  conv3x3_pad_stream #(
    .IMG_W(9), .IMG_H(9), .DATA_W(8), .COEF_W(8), .OUT_W(8), .SHIFT(0)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .coef_we_i(coef_we), .coef_addr_i(coef_addr),
    .coef_data_i(coef_data), .start_i(start), .s_valid_i(s_valid), .s_ready_o(s_ready),
    .s_data_i(s_data), .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data),
    .m_last_o(m_last), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // mode 0: gradient 3r+c+4, mode 1: constant 255, mode 2: constant 100
  function automatic int pix(input int mode, input int idx);
    if (mode == 0) return 3 * (idx / 9) + (idx % 9) + 4;
    if (mode == 1) return 255;
    return 100;
  endfunction

  // kern 0: identity, 1: all ones, 2: centre -1. Returns -1 where no value is checked.
  function automatic int expv(input int kern, input int mode, input int idx);
    int r, c, n;
    r = idx / 9;
    c = idx % 9;
    if (kern == 0) return pix(mode, idx);
    if (kern == 1 && mode == 0) begin
      if (idx == 0)  return 24;
      if (idx == 40) return 180;
      if (idx == 80) return 136;
      return -1;
    end
    if (kern == 1) begin
      n = ((r == 0 || r == 8) ? 2 : 3) * ((c == 0 || c == 8) ? 2 : 3);
      if (SAT) return 255;
      if (n == 4) return 252;
      if (n == 6) return 250;
      return 247;
    end
    return SAT ? 0 : 156;
  endfunction

  task automatic load_kernel(input int kern);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      coef_we   = 1'b1;
      coef_addr = 4'(k);
      if (kern == 1)      coef_data = 8'sd1;
      else if (kern == 2) coef_data = (k == 4) ? -8'sd1 : 8'sd0;
      else                coef_data = (k == 4) ? 8'sd1 : 8'sd0;
    end
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic run_frame(input int kern, input int mode, input int stall_at,
                           input int rst_at, input bit poke);
    int in_idx = 0, out_idx = 0, run_cyc = 0, stall_cnt = 0, cyc = 0, e;
    bit stalled = 1'b0, last_seen = 1'b0, finished = 1'b0, aborted = 1'b0;
    logic [7:0] held = 8'd0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("busy_after_start", 32'(busy), 32'd1);
    while (cyc < 600 && !finished) begin
      if (last_seen) begin
        check("done_pulse", 32'(done), 32'd1);
        check("busy_at_done", 32'(busy), 32'd0);
        @(negedge clk);
        #1;
        check("done_falls", 32'(done), 32'd0);
        finished = 1'b1;
      end else if (m_valid && out_idx == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        s_valid = 1'b0;
        @(negedge clk);
        #1;
        check("idle_after_rst", 32'(busy), 32'd0);
        finished = 1'b1;
        aborted = 1'b1;
      end else begin
        if (busy && !(m_valid && m_last)) run_cyc++;
        if (stall_cnt > 0) begin
          check("stall_data", 32'(m_data), 32'(held));
          check("stall_valid", 32'(m_valid), 32'd1);
        end
        if (m_valid && out_idx == stall_at && !stalled) begin
          stalled   = 1'b1;
          stall_cnt = 5;
          held      = m_data;
        end
        m_ready   = (stall_cnt == 0);
        if (stall_cnt > 0) stall_cnt--;
        s_valid   = 1'b1;
        s_data    = (in_idx < 81) ? 8'(pix(mode, in_idx)) : 8'd0;
        coef_we   = poke && (cyc == 50);
        coef_addr = 4'd4;
        coef_data = 8'sd0;
        #1;
        if (!m_ready) check("stall_s_ready", 32'(s_ready), 32'd0);
        if (s_valid && s_ready) in_idx++;
        if (m_valid && m_ready) begin
          e = expv(kern, mode, out_idx);
          if (e >= 0) check($sformatf("data[%0d]", out_idx), 32'(m_data), 32'(e));
          check($sformatf("last[%0d]", out_idx), 32'(m_last), 32'(out_idx == 80));
          if (m_last) last_seen = 1'b1;
          out_idx++;
        end
        cyc++;
        @(negedge clk);
      end
    end
    coef_we = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    if (!finished) check("frame_timeout", 32'd0, 32'd1);
    if (finished && !aborted) begin
      check("out_count", 32'(out_idx), 32'd81);
      check("in_count", 32'(in_idx), 32'd81);
      if (stall_at < 0) check("run_cycles", 32'(run_cyc), 32'd121);
    end
  endtask

  initial begin
    #1;
    check("reset_s_ready", 32'(s_ready), 32'd0);
    check("reset_m_valid", 32'(m_valid), 32'd0);
    check("reset_m_data", 32'(m_data), 32'd0);
    check("reset_m_last", 32'(m_last), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    #20;
    rst_n = 1'b1;
    run_frame(0, 0, -1, -1, 1'b0);
    run_frame(0, 0, 40, -1, 1'b1);
    load_kernel(1);
    run_frame(1, 0, -1, -1, 1'b0);
    run_frame(1, 1, -1, -1, 1'b0);
    load_kernel(2);
    run_frame(2, 2, -1, -1, 1'b0);
    run_frame(2, 2, -1, 30, 1'b0);
    run_frame(0, 0, -1, -1, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv3x3_pad_stream.md
# conv3x3_pad_stream

Parametrised streaming 3x3 convolution engine with built-in one-pixel zero padding. It is the successor to the fixed 9x9, 8-bit padding/convolution block. Pixels arrive as a raster-order valid/ready stream; the block generates the zero border internally, so no pre-padded matrix is needed. It holds a run-time loadable signed kernel and emits a same-size (IMG_H x IMG_W) output stream. It sits between the pixel source and the downstream feature buffer.

## Interface
- IMG_W, 9: image width in pixels (>=2)
- IMG_H, 9: image height in rows (>=2)
- DATA_W, 8: unsigned input pixel width
- COEF_W, 8: signed two's-complement coefficient width
- OUT_W, 8: unsigned output pixel width
- SHIFT, 0: arithmetic right shift applied to the accumulator before output conversion
- Accumulator width is derived internally: ACC_W = DATA_W+COEF_W+4. It is not a parameter.
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- coef_we  in  1  coefficient write strobe; honoured only in IDLE
- coef_addr  in  4  coefficient index 3*row+col (0..8); 9..15 ignored
- coef_data  in  COEF_W  signed coefficient value
- start  in  1  begin one frame; honoured only in IDLE
- s_valid  in  1  input pixel valid
- s_ready  out  1  input pixel accepted when s_valid && s_ready
- s_data  in  DATA_W  input pixel, raster order
- m_valid  out  1  output pixel valid
- m_ready  in  1  downstream accepts when m_valid && m_ready
- m_data  out  OUT_W  output pixel
- m_last  out  1  high with output pixel (IMG_H-1, IMG_W-1)
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse at frame completion

## Operation
- FSM states: IDLE -> (start) RUN -> (last output handshake) DONE -> IDLE. DONE lasts one cycle and drives done=1.
- In RUN, a scan counter (pr, pc) walks the padded grid of (IMG_H+2) x (IMG_W+2) positions in raster order. Two line buffers of IMG_W+2 entries plus a 3x3 window register hold the neighbourhood.
- Interior position (1<=pr<=IMG_H, 1<=pc<=IMG_W): the counter advances only on an input handshake, and s_data enters the window.
- Border position: a zero enters the window and the counter advances with no input consumed. s_ready=0 at border positions.
- A position advances only if the output slot is free (!m_valid || m_ready). s_ready = RUN && interior && (!m_valid || m_ready).
- When a position with pr>=2 and pc>=2 advances, output (pr-2, pc-2) is computed from the window centred on padded position (pr-1, pc-1).
- The output is registered, and m_valid rises on the next edge.
- Output value: y = sum over i,j of k[i][j]*p(r+i-1, c+j-1), with pixels outside the image equal to 0. The sum is signed, in ACC_W bits; then y = y >>> SHIFT.
- Coefficients are stored in 9 registers. Reset loads the identity kernel: index 4 = 1, all others 0.
- Writes in RUN or DONE are dropped. start outside IDLE is ignored.
- m_data, m_valid and m_last hold stable while m_valid && !m_ready.
- Reset mid-frame returns the block to IDLE and discards the frame. Stale line-buffer contents are harmless, because padded row 0 overwrites them before they are used.

## Timing
- Reset values: s_ready=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0, state=IDLE, counters=0.
- start is sampled in IDLE; busy=1 on the next cycle.
- With no stalls, a frame takes (IMG_H+2)*(IMG_W+2) RUN cycles. For 9x9 that is 121 cycles.
- First m_valid: 1 cycle after scan index 2*(IMG_W+2)+2 advances.
- Output rate: at most one pixel per cycle. Border positions give bubbles on the input side and never block the output.
- done pulses the cycle after the m_last handshake. busy falls the same cycle.

## Configuration
- CONV_SAT_EN defined: after shifting, y<0 gives 0, y>2^OUT_W-1 gives 2^OUT_W-1, otherwise y is passed through.
- CONV_SAT_EN undefined: m_data = y[OUT_W-1:0]. This truncates modulo 2^OUT_W and matches the legacy block.

## Test plan
- Reset kernel (identity), SHIFT=0, 9x9 frame with p(r,c)=3r+c+4 -> m_data equals the input pixel for pixel, m_last on pixel 81, done one cycle later, 121 RUN cycles with m_ready=1.
- All-ones kernel, same frame -> out(0,0)=24, out(4,4)=180, out(8,8)=136.
- All-ones kernel, constant input 255 -> interior = 255 with CONV_SAT_EN and 247 without; corner = 255 with CONV_SAT_EN and 252 (1020 mod 256) without.
- Kernel with only index 4 = -1, input 100 -> output 0 with CONV_SAT_EN and 156 without.
- Identity kernel, m_ready held low for 5 cycles at output 40 -> m_data is stable, s_ready=0, no pixel is lost or duplicated, and all 81 outputs are correct.
- Assert rst low at output 30, then run a fresh frame -> all outputs reset, IDLE reached, and the second frame matches the identity test exactly. coef_we pulsed during RUN leaves the kernel unchanged.
